mem_stage_param: RTL and testbench

//  Parametrised ARM-pipeline MEM stage: word-addressed data memory, MEM/WB pipeline register,

---
 rtl/mem_stage_param_if.sv | 29 ++
 rtl/mem_stage_param.sv | 117 +++++++++++
 tb/tb_mem_stage_param.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_param_if.sv
// Bus between the EXE/MEM register, the MEM stage and the WB stage.
// The upstream (master) side drives instruction fields and observes ready and the MEM/WB register.
interface mem_stage_param_if #(
    parameter int unsigned DATA_W = 32
);
    logic              wb_en_in;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] val_rm;
    logic [3:0]        wb_dest_in;
    logic              ready;
    logic              wb_en_out;
    logic              mem_r_en_out;
    logic [DATA_W-1:0] alu_res_out;
    logic [DATA_W-1:0] mem_out;
    logic [3:0]        wb_dest_out;
    logic              addr_err_out;

    modport master (
        output wb_en_in, mem_r_en, mem_w_en, alu_res, val_rm, wb_dest_in,
        input  ready, wb_en_out, mem_r_en_out, alu_res_out, mem_out, wb_dest_out, addr_err_out
    );

    modport slave (
        input  wb_en_in, mem_r_en, mem_w_en, alu_res, val_rm, wb_dest_in,
        output ready, wb_en_out, mem_r_en_out, alu_res_out, mem_out, wb_dest_out, addr_err_out
    );
endinterface

// File: rtl/mem_stage_param.sv
// ARM pipeline MEM stage: word-addressed data memory behind a base address, optional wait
// states with a ready/freeze handshake, and the MEM/WB pipeline register.
module mem_stage_param #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                rst,
    mem_stage_param_if.slave    bus
);
    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned OFF_SH = $clog2(BYTES);
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [DATA_W-1:0] BASE       = DATA_W'(BASE_ADDR);
    localparam logic [DATA_W-1:0] ALIGN_MASK = DATA_W'(BYTES - 1);
    localparam logic [DATA_W-1:0] DEPTH_W    = DATA_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(WAIT_STATES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stage_ready;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] off;
    logic [DATA_W-1:0] widx;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_data;
    logic              access;
    logic              bad;

    // Address translation and error detection; bad addresses read as zero.
    always_comb begin
        off     = bus.alu_res - BASE;
        widx    = off >> OFF_SH;
        idx     = widx[IDX_W-1:0];
        access  = bus.mem_r_en | bus.mem_w_en;
        bad     = (bus.alu_res < BASE) | (widx >= DEPTH_W) | ((off & ALIGN_MASK) != '0);
        rd_data = bad ? '0 : mem[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (access && (WAIT_STATES > 0)) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stage_ready = 1'b1;
        case (state_q)
            IDLE:    stage_ready = !(access && (WAIT_STATES > 0));
            BUSY:    stage_ready = (cnt_q == '0);
            default: stage_ready = 1'b1;
        endcase
    end

    assign bus.ready = stage_ready;

    // Stores commit only on the final (ready) cycle of an op and never under reset.
    always_ff @(posedge clk) begin
        if (!rst && stage_ready && bus.mem_w_en && !bad) begin
            mem[idx] <= bus.val_rm;
        end
    end

    // MEM/WB register: bubble control bits while stalled, data fields hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wb_en_out    <= 1'b0;
            bus.mem_r_en_out <= 1'b0;
            bus.alu_res_out  <= '0;
            bus.mem_out      <= '0;
            bus.wb_dest_out  <= '0;
            bus.addr_err_out <= 1'b0;
        end else if (stage_ready) begin
            bus.wb_en_out    <= bus.wb_en_in;
            bus.mem_r_en_out <= bus.mem_r_en;
            bus.alu_res_out  <= bus.alu_res;
            bus.mem_out      <= rd_data;
            bus.wb_dest_out  <= bus.wb_dest_in;
            bus.addr_err_out <= access & bad;
        end else begin
            bus.wb_en_out    <= 1'b0;
            bus.mem_r_en_out <= 1'b0;
            bus.addr_err_out <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_stage_param.sv
// Bench for mem_stage_param: a zero-wait and a three-wait instance, checked against a
// word-array memory model, directed vector tables and hand-written stall/reset sequences.
module tb_mem_stage_param;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned BASE  = 1024;

    typedef struct packed {
        logic        wb;
        logic        r;
        logic        err;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [3:0]  dest;
    } exp_t;

    typedef struct packed {
        logic        wb;
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] v;
        logic [3:0]  d;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst0, rst3;
    always #5 clk = ~clk;

    mem_stage_param_if #(.DATA_W(DW)) b0 ();
    mem_stage_param_if #(.DATA_W(DW)) b3 ();

    mem_stage_param #(.DATA_W(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst0), .bus(b0));
    mem_stage_param #(.DATA_W(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) u3 (
        .clk(clk), .rst(rst3), .bus(b3));

    int n_run  = 0;
    int n_fail = 0;
    logic [31:0] m0 [DEPTH];
    logic [31:0] m3 [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_bad(input logic [31:0] a);
        longint unsigned off;
        if (a < 32'(BASE)) return 1'b1;
        off = longint'(a) - longint'(BASE);
        if (off % 4 != 0) return 1'b1;
        if (off / 4 >= longint'(DEPTH)) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: expected MEM/WB contents for one completed op, updating the model memory.
    task automatic model(input bit sel3, input logic wb, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] v, input logic [3:0] d,
                         output exp_t e);
        bit bad;
        int idx;
        bad    = is_bad(a);
        e.wb   = wb;
        e.r    = r;
        e.alu  = a;
        e.dest = d;
        e.err  = (r | w) & bad;
        e.mem  = 32'h0;
        if (!bad) begin
            idx = int'((a - 32'(BASE)) / 4);
            e.mem = sel3 ? m3[idx] : m0[idx];
            if (w) begin
                if (sel3) m3[idx] = v;
                else      m0[idx] = v;
            end
        end
    endtask

    task automatic check_out(input string tag, input logic wb, input logic r, input logic err,
                             input logic [31:0] alu, input logic [31:0] mem,
                             input logic [3:0] dest, input exp_t e);
        chk({tag, " wb_en_out"},    32'(wb),   32'(e.wb));
        chk({tag, " mem_r_en_out"}, 32'(r),    32'(e.r));
        chk({tag, " addr_err_out"}, 32'(err),  32'(e.err));
        chk({tag, " alu_res_out"},  alu,       e.alu);
        chk({tag, " mem_out"},      mem,       e.mem);
        chk({tag, " wb_dest_out"},  32'(dest), 32'(e.dest));
    endtask

    // Zero-wait instance: one cycle per instruction, ready must stay high.
    task automatic op0(input logic wb, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] v, input logic [3:0] d, input exp_t e, input string tag);
        b0.wb_en_in = wb; b0.mem_r_en = r; b0.mem_w_en = w;
        b0.alu_res = a; b0.val_rm = v; b0.wb_dest_in = d;
        #1;
        chk({tag, " ready"}, 32'(b0.ready), 32'd1);
        @(posedge clk); #1;
        check_out(tag, b0.wb_en_out, b0.mem_r_en_out, b0.addr_err_out,
                  b0.alu_res_out, b0.mem_out, b0.wb_dest_out, e);
        b0.mem_r_en = 1'b0; b0.mem_w_en = 1'b0; b0.wb_en_in = 1'b0;
    endtask

    // Three-wait instance: mem ops take four cycles, bubbles in MEM/WB while stalled.
    task automatic op3(input logic wb, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] v, input logic [3:0] d, input string tag);
        exp_t e;
        int   nc;
        model(1'b1, wb, r, w, a, v, d, e);
        nc = (r | w) ? 4 : 1;
        b3.wb_en_in = wb; b3.mem_r_en = r; b3.mem_w_en = w;
        b3.alu_res = a; b3.val_rm = v; b3.wb_dest_in = d;
        for (int k = 0; k < nc; k++) begin
            #1;
            chk($sformatf("%s ready c%0d", tag, k), 32'(b3.ready), 32'(k == nc - 1));
            @(posedge clk); #1;
            if (k < nc - 1) begin
                chk($sformatf("%s bubble wb c%0d", tag, k),  32'(b3.wb_en_out),    32'd0);
                chk($sformatf("%s bubble rd c%0d", tag, k),  32'(b3.mem_r_en_out), 32'd0);
                chk($sformatf("%s bubble err c%0d", tag, k), 32'(b3.addr_err_out), 32'd0);
            end
        end
        check_out(tag, b3.wb_en_out, b3.mem_r_en_out, b3.addr_err_out,
                  b3.alu_res_out, b3.mem_out, b3.wb_dest_out, e);
        b3.mem_r_en = 1'b0; b3.mem_w_en = 1'b0; b3.wb_en_in = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned mode;
        mode = $urandom_range(0, 9);
        if (mode <= 5) return 32'(BASE) + 32'(4 * $urandom_range(0, DEPTH - 1));
        if (mode == 6) return 32'(BASE) + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
        if (mode == 7) return 32'(BASE) + 32'(4 * (DEPTH + $urandom_range(0, 100)));
        if (mode == 8) return 32'($urandom_range(0, BASE - 1));
        return 32'($urandom);
    endfunction

    vec_t vt [11];

    initial begin
        exp_t        e;
        logic        wb, r, w;
        logic [31:0] a, v;
        logic [3:0]  d;

        vt[0]  = '{1'b0, 1'b0, 1'b1, 32'h400, 32'hDEADBEEF, 4'd1, '{1'b0, 1'b0, 1'b0, 32'h400, 32'hC0DE0000, 4'd1}};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 32'h400, 32'h0,        4'd2, '{1'b1, 1'b1, 1'b0, 32'h400, 32'hDEADBEEF, 4'd2}};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 32'h55,  32'h0,        4'd7, '{1'b1, 1'b0, 1'b0, 32'h55,  32'h0,        4'd7}};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 32'h500, 32'hFFFF0000, 4'd0, '{1'b0, 1'b0, 1'b1, 32'h500, 32'h0,        4'd0}};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 32'h402, 32'h0,        4'd3, '{1'b1, 1'b1, 1'b1, 32'h402, 32'h0,        4'd3}};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 32'h3FC, 32'h0,        4'd4, '{1'b1, 1'b1, 1'b1, 32'h3FC, 32'h0,        4'd4}};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 32'h4FC, 32'h0,        4'd5, '{1'b1, 1'b1, 1'b0, 32'h4FC, 32'hC0DE003F, 4'd5}};
        vt[7]  = '{1'b1, 1'b1, 1'b1, 32'h404, 32'h11112222, 4'd6, '{1'b1, 1'b1, 1'b0, 32'h404, 32'hC0DE0001, 4'd6}};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 32'h404, 32'h0,        4'd8, '{1'b1, 1'b1, 1'b0, 32'h404, 32'h11112222, 4'd8}};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 32'h404, 32'h0,        4'd9, '{1'b0, 1'b0, 1'b0, 32'h404, 32'h11112222, 4'd9}};
        vt[10] = '{1'b1, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,   4'hA, '{1'b1, 1'b1, 1'b1, 32'hFFFFFFFC, 32'h0,   4'hA}};

        b0.wb_en_in = 0; b0.mem_r_en = 0; b0.mem_w_en = 0; b0.alu_res = 0; b0.val_rm = 0; b0.wb_dest_in = 0;
        b3.wb_en_in = 0; b3.mem_r_en = 0; b3.mem_w_en = 0; b3.alu_res = 0; b3.val_rm = 0; b3.wb_dest_in = 0;
        rst0 = 1'b1; rst3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        e = '0;
        check_out("reset u0", b0.wb_en_out, b0.mem_r_en_out, b0.addr_err_out,
                  b0.alu_res_out, b0.mem_out, b0.wb_dest_out, e);
        check_out("reset u3", b3.wb_en_out, b3.mem_r_en_out, b3.addr_err_out,
                  b3.alu_res_out, b3.mem_out, b3.wb_dest_out, e);
        chk("reset ready u3", 32'(b3.ready), 32'd1);
        rst0 = 1'b0; rst3 = 1'b0;

        // Known contents so the vector table can carry constant expectations.
        for (int i = 0; i < int'(DEPTH); i++) begin
            model(1'b0, 1'b0, 1'b0, 1'b1, 32'(BASE + 4 * i), 32'hC0DE0000 | 32'(i), 4'd0, e);
            op0(1'b0, 1'b0, 1'b1, 32'(BASE + 4 * i), 32'hC0DE0000 | 32'(i), 4'd0, e, "init0");
        end

        for (int i = 0; i < 11; i++) begin
            model(1'b0, vt[i].wb, vt[i].r, vt[i].w, vt[i].a, vt[i].v, vt[i].d, e);
            op0(vt[i].wb, vt[i].r, vt[i].w, vt[i].a, vt[i].v, vt[i].d, vt[i].e, $sformatf("vec%0d", i));
        end

        // Out-of-range store must have left every word alone.
        for (int i = 0; i < int'(DEPTH); i++) begin
            model(1'b0, 1'b1, 1'b1, 1'b0, 32'(BASE + 4 * i), 32'h0, 4'd1, e);
            op0(1'b1, 1'b1, 1'b0, 32'(BASE + 4 * i), 32'h0, 4'd1, e, $sformatf("readback%0d", i));
        end

        for (int i = 0; i < 200; i++) begin
            wb = 1'($urandom); r = 1'($urandom); w = 1'($urandom);
            a = rand_addr(); v = $urandom; d = 4'($urandom);
            model(1'b0, wb, r, w, a, v, d, e);
            op0(wb, r, w, a, v, d, e, $sformatf("rnd0_%0d", i));
        end

        for (int i = 0; i < int'(DEPTH); i++)
            op3(1'b0, 1'b0, 1'b1, 32'(BASE + 4 * i), $urandom, 4'd0, "init3");

        op3(1'b0, 1'b0, 1'b1, 32'd1028, 32'h12345678, 4'd0, "t2 store");
        op3(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd5, "t2 load");
        chk("t2 literal mem_out", b3.mem_out, 32'h12345678);
        op3(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd7, "u3 nonmem");
        op3(1'b0, 1'b0, 1'b1, 32'(BASE + 4 * DEPTH), 32'hFFFF0000, 4'd0, "u3 bad store");
        op3(1'b1, 1'b1, 1'b0, 32'd1026, 32'h0, 4'd2, "u3 misaligned");

        for (int i = 0; i < 60; i++) begin
            wb = 1'($urandom); r = 1'($urandom); w = 1'($urandom);
            a = rand_addr(); v = $urandom; d = 4'($urandom);
            op3(wb, r, w, a, v, d, $sformatf("rnd3_%0d", i));
        end

        // Reset during the wait window aborts the store.
        b3.wb_en_in = 1'b0; b3.mem_r_en = 1'b0; b3.mem_w_en = 1'b1;
        b3.alu_res = 32'd1032; b3.val_rm = 32'hA5A5A5A5; b3.wb_dest_in = 4'd3;
        #1;
        chk("t6 ready c0", 32'(b3.ready), 32'd0);
        @(posedge clk); #1;
        rst3 = 1'b1;
        #1;
        chk("t6 ready c1", 32'(b3.ready), 32'd0);
        @(posedge clk); #1;
        e = '0;
        check_out("t6 reset", b3.wb_en_out, b3.mem_r_en_out, b3.addr_err_out,
                  b3.alu_res_out, b3.mem_out, b3.wb_dest_out, e);
        b3.mem_w_en = 1'b0;
        rst3 = 1'b0;
        #1;
        chk("t6 ready idle", 32'(b3.ready), 32'd1);
        @(posedge clk); #1;
        op3(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd4, "t6 readback");
        chk("t6 not A5", 32'(b3.mem_out == 32'hA5A5A5A5), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
